// File: rtl/zigzag_pkg.sv
// Shared constants and state encoding for the rail-fence (zigzag) cipher blocks.
// No logic; imported by the encryption top and its index sequencer.
package zigzag_pkg;

    localparam logic [7:0] START_TOKEN_DEFAULT = 8'hFA;

    localparam int KEY_RAIL2 = 2;
    localparam int KEY_RAIL3 = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/zigzag_index_gen.sv
// Rail-fence read-index sequencer: produces buffer index pos for each emitted character.
// Latency: pos is valid the cycle after start, then advances one index per cycle.
// Backpressure: none; it runs freely until cnt reaches n, then flags last.
module zigzag_index_gen
    import zigzag_pkg::*;
#(
    parameter int KEY_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] key_q,
    input  logic [KEY_WIDTH-1:0] n,
    output logic [KEY_WIDTH-1:0] pos,
    output logic                 last
);

    logic [KEY_WIDTH-1:0] rail;
    logic [KEY_WIDTH-1:0] cnt;
    logic [KEY_WIDTH-1:0] step;
    logic [KEY_WIDTH-1:0] nxt;
    logic                 active;

    // Key 3: the outer rails skip a full zigzag period, the middle rail half of it.
    always_comb begin
        step = KEY_WIDTH'(1);
        if (key_q == KEY_WIDTH'(KEY_RAIL2)) begin
            step = KEY_WIDTH'(2);
        end else if (key_q == KEY_WIDTH'(KEY_RAIL3)) begin
            step = (rail == KEY_WIDTH'(1)) ? KEY_WIDTH'(2) : KEY_WIDTH'(4);
        end
    end

    assign nxt  = pos + step;
    assign last = active && (cnt == n);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            rail   <= '0;
            pos    <= '0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            rail   <= '0;
            pos    <= '0;
            cnt    <= '0;
        end else if (active) begin
            if (cnt < n) begin
                cnt <= cnt + KEY_WIDTH'(1);
                if (nxt < n) begin
                    pos <= nxt;
                end else begin
                    rail <= rail + KEY_WIDTH'(1);
                    pos  <= rail + KEY_WIDTH'(1);
                end
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/zigzag_encryption.sv
// Buffers plaintext, then on the start token streams rail-fence ciphertext one char per cycle.
// Latency: first ciphertext char one cycle after the token edge; n chars back to back.
// Backpressure: busy is high for n+1 cycles; valid_i is ignored while emitting.
module zigzag_encryption
    import zigzag_pkg::*;
#(
    parameter int                   D_WIDTH                = 8,
    parameter int                   KEY_WIDTH              = 16,
    parameter int                   MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0]   START_ENCRYPTION_TOKEN = D_WIDTH'(START_TOKEN_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    state_t               state;
    logic [KEY_WIDTH-1:0] n;
    logic [KEY_WIDTH-1:0] key_q;
    logic [KEY_WIDTH-1:0] pos;
    logic                 last;
    logic                 start;
    logic [D_WIDTH-1:0]   rd_dat;
    logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];

    assign start = (state == COLLECT) && valid_i && (data_i == START_ENCRYPTION_TOKEN);

    // Full-width compare keeps the read mux free of truncated index bits.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < MAX_NOF_CHARS; i++) begin
            if (pos == KEY_WIDTH'(i)) begin
                rd_dat = buf_q[i];
            end
        end
    end

    zigzag_index_gen #(
        .KEY_WIDTH (KEY_WIDTH)
    ) u_index_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .key_q (key_q),
        .n     (n),
        .pos   (pos),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= COLLECT;
            n       <= '0;
            key_q   <= '0;
            busy    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            for (int i = 0; i < MAX_NOF_CHARS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    valid_o <= 1'b0;
                    data_o  <= '0;
                    if (start) begin
                        key_q <= key;
                        busy  <= 1'b1;
                        state <= EMIT;
                    end else if (valid_i && (n < KEY_WIDTH'(MAX_NOF_CHARS))) begin
                        for (int i = 0; i < MAX_NOF_CHARS; i++) begin
                            if (n == KEY_WIDTH'(i)) begin
                                buf_q[i] <= data_i;
                            end
                        end
                        n <= n + KEY_WIDTH'(1);
                    end
                end
                EMIT: begin
                    if (last) begin
                        valid_o <= 1'b0;
                        data_o  <= '0;
                        busy    <= 1'b0;
                        n       <= '0;
                        state   <= COLLECT;
                        for (int i = 0; i < MAX_NOF_CHARS; i++) begin
                            buf_q[i] <= '0;
                        end
                    end else begin
                        valid_o <= 1'b1;
                        data_o  <= rd_dat;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_zigzag_encryption.sv
// Directed testbench for zigzag_encryption with hand-computed ciphertexts.
module tb_zigzag_encryption;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] key;
    logic        busy;
    logic [7:0]  data_o;
    logic        valid_o;

    int checks;
    int errors;

    logic [7:0] out_q [64];
    logic [7:0] dec_q [64];
    int         out_n;
    int         busy_fall;
    bit         gap;

    zigzag_encryption dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key     (key),
        .busy    (busy),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            data_i  = s[i];
            valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
    endtask

    task automatic send_token(input logic [15:0] k);
        data_i  = 8'hFA;
        valid_i = 1'b1;
        key     = k;
        tick();
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    // Records emitted chars and the cycle (relative to the token edge) on which busy drops.
    task automatic capture(input int budget, input bit junk);
        out_n     = 0;
        busy_fall = -1;
        gap       = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (junk) begin
                valid_i = 1'b1;
                data_i  = (c == 10) ? 8'hFA : 8'h30 + 8'(c);
            end else begin
                valid_i = 1'b0;
            end
            tick();
            if (valid_o) begin
                if (out_n != c - 1) gap = 1'b1;
                out_q[out_n] = data_o;
                out_n++;
            end
            if (!busy) begin
                busy_fall = c;
                break;
            end
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    // Independent rail-fence decoder used for the round-trip check.
    function automatic void decrypt(input int k, input int n);
        int  idx;
        int  i;
        bit  down;
        idx = 0;
        for (int r = 0; r < k; r++) begin
            i    = r;
            down = 1'b1;
            while (i < n) begin
                dec_q[i] = out_q[idx];
                idx++;
                if (r == 0 || r == k - 1) begin
                    i += 2 * (k - 1);
                end else begin
                    i += down ? 2 * (k - 1 - r) : 2 * r;
                    down = !down;
                end
            end
        end
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h41;
        key     = 16'd3;
        tick();
        tick();
        valid_i = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++;
        if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_key3();
        string exp;
        exp = "HOLELWRDLO";
        send_str("HELLOWORLD");
        send_token(16'd3);
        checks++;
        if (busy !== 1'b1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL key3_token_edge got busy=%b valid=%b want 1 0", busy, valid_o);
        end
        capture(20, 1'b0);
        checks++;
        if (out_n !== 10) begin errors++; $display("FAIL key3_count got %0d want 10", out_n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_q[i] !== exp[i]) begin
                errors++; $display("FAIL key3_char%0d got %h want %h", i, out_q[i], exp[i]);
            end
        end
        checks++;
        if (gap !== 1'b0) begin errors++; $display("FAIL key3_no_bubble got gap=%b want 0", gap); end
        checks++;
        if (busy_fall !== 11) begin errors++; $display("FAIL key3_busy_fall got %0d want 11", busy_fall); end
        checks++;
        if (valid_o !== 1'b0 || data_o !== 8'h00) begin
            errors++; $display("FAIL key3_idle got valid=%b data=%h want 0 00", valid_o, data_o);
        end
    endtask

    task automatic test_key2_roundtrip();
        string exp;
        string plain;
        exp   = "HLOOLELWRD";
        plain = "HELLOWORLD";
        send_str(plain);
        send_token(16'd2);
        capture(20, 1'b0);
        checks++;
        if (out_n !== 10) begin errors++; $display("FAIL key2_count got %0d want 10", out_n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_q[i] !== exp[i]) begin
                errors++; $display("FAIL key2_char%0d got %h want %h", i, out_q[i], exp[i]);
            end
        end
        decrypt(2, 10);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dec_q[i] !== plain[i]) begin
                errors++; $display("FAIL key2_roundtrip%0d got %h want %h", i, dec_q[i], plain[i]);
            end
        end
        checks++;
        if (busy_fall !== 11) begin errors++; $display("FAIL key2_busy_fall got %0d want 11", busy_fall); end
    endtask

    task automatic test_single_and_empty();
        send_str("A");
        send_token(16'd3);
        capture(10, 1'b0);
        checks++;
        if (out_n !== 1 || out_q[0] !== 8'h41) begin
            errors++; $display("FAIL single_char got n=%0d c=%h want 1 41", out_n, out_q[0]);
        end
        checks++;
        if (busy_fall !== 2) begin errors++; $display("FAIL single_busy_fall got %0d want 2", busy_fall); end
        send_token(16'd3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy got %b want 1", busy); end
        capture(10, 1'b0);
        checks++;
        if (out_n !== 0) begin errors++; $display("FAIL empty_count got %0d want 0", out_n); end
        checks++;
        if (busy_fall !== 1) begin errors++; $display("FAIL empty_busy_fall got %0d want 1", busy_fall); end
    endtask

    task automatic test_passthrough();
        string exp;
        exp = "ABC";
        send_str("ABC");
        send_token(16'd5);
        key = 16'd2;
        capture(10, 1'b0);
        checks++;
        if (out_n !== 3) begin errors++; $display("FAIL pass_count got %0d want 3", out_n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_q[i] !== exp[i]) begin
                errors++; $display("FAIL pass_char%0d got %h want %h", i, out_q[i], exp[i]);
            end
        end
        checks++;
        if (busy_fall !== 4) begin errors++; $display("FAIL pass_busy_fall got %0d want 4", busy_fall); end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        for (int i = 0; i < 52; i++) begin
            data_i  = 8'h61 + 8'(i);
            valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        send_token(16'd2);
        capture(70, 1'b1);
        checks++;
        if (out_n !== 50) begin errors++; $display("FAIL ovf_count got %0d want 50", out_n); end
        checks++;
        if (busy_fall !== 51) begin errors++; $display("FAIL ovf_busy_fall got %0d want 51", busy_fall); end
        for (int k = 0; k < 50; k++) begin
            e = (k < 25) ? 8'h61 + 8'(2 * k) : 8'h61 + 8'(2 * (k - 25) + 1);
            checks++;
            if (out_q[k] !== e) begin
                errors++; $display("FAIL ovf_char%0d got %h want %h", k, out_q[k], e);
            end
        end
        // Junk sent during emission must not have been stored.
        send_token(16'd2);
        capture(10, 1'b0);
        checks++;
        if (out_n !== 0 || busy_fall !== 1) begin
            errors++; $display("FAIL ovf_junk_ignored got n=%0d fall=%0d want 0 1", out_n, busy_fall);
        end
    endtask

    task automatic test_reset_mid();
        string exp;
        int    seen;
        exp  = "AB";
        seen = 0;
        send_str("HELLOWORLD");
        send_token(16'd3);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (valid_o) seen++;
        end
        checks++;
        if (seen !== 3 || data_o !== 8'h4C) begin
            errors++; $display("FAIL mid_pre_reset got n=%0d last=%h want 3 4c", seen, data_o);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (valid_o !== 1'b0 || busy !== 1'b0 || data_o !== 8'h00) begin
            errors++; $display("FAIL mid_reset got v=%b b=%b d=%h want 0 0 00", valid_o, busy, data_o);
        end
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (valid_o || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_quiet got %0d active cycles want 0", seen); end
        send_str("AB");
        send_token(16'd2);
        capture(10, 1'b0);
        checks++;
        if (out_n !== 2 || out_q[0] !== exp[0] || out_q[1] !== exp[1]) begin
            errors++; $display("FAIL mid_after got n=%0d %h %h want 2 41 42", out_n, out_q[0], out_q[1]);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        key     = 16'd0;
        test_reset();
        test_key3();
        test_key2_roundtrip();
        test_single_and_empty();
        test_passthrough();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
